fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 60 ++++++
 rtl/fetch_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared defaults and state encoding for the fetch controller.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 9;
    localparam int IMEM_AW_DEF = 12;

    localparam logic [INSTR_W_DEF-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Single-entry valid/ready register for the fetched instruction.
// Revision : 1.0
// ============================================================================
module fetch_buffer #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;

    // Flush only drops valid; payload is left as-is since nobody looks at it.
    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            addr_d  = load_addr;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign addr  = addr_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Brief    : Sequential instruction fetch with halt, branch redirect and
//            address range fault; memory sits beside this block.
// Revision : 1.0
// ============================================================================
module fetch_controller #(
    parameter int                 PC_W       = fetch_pkg::PC_W_DEF,
    parameter int                 INSTR_W    = fetch_pkg::INSTR_W_DEF,
    parameter int                 IMEM_AW    = fetch_pkg::IMEM_AW_DEF,
    parameter logic [INSTR_W-1:0] HALT_INSTR = fetch_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [31:0]        instr_count
);

    import fetch_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic              w_accept;
    logic              w_load;
    logic              w_pc_oor;
    logic              buf_load;
    logic              buf_flush;

    assign w_accept = instr_valid && instr_ready;
    assign w_load   = !instr_valid || instr_ready;

    generate
        if (PC_W > IMEM_AW) begin : g_range_chk
            assign w_pc_oor = |pc_q[PC_W-1:IMEM_AW];
        end else begin : g_no_range_chk
            assign w_pc_oor = 1'b0;
        end
    endgenerate

    // Branch beats range check, range check beats halt, halt beats load.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q + 32'(w_accept);
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d      = branch_target;
                    buf_flush = 1'b1;
                end else if (w_pc_oor) begin
                    state_d   = ST_FAULT;
                    buf_flush = 1'b1;
                end else if (w_load) begin
                    if (imem_instr == HALT_INSTR) begin
                        state_d   = ST_DONE;
                        buf_flush = 1'b1;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pc_d      = '0;
                    count_d   = '0;
                    buf_flush = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    fetch_buffer #(
        .DATA_W (INSTR_W),
        .ADDR_W (PC_W)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .flush     (buf_flush),
        .ready     (instr_ready),
        .load_data (imem_instr),
        .load_addr (pc_q),
        .data      (instr_out),
        .addr      (instr_pc),
        .valid     (instr_valid)
    );

    assign imem_pc     = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule
`default_nettype wire
